// File: rtl/one_hot_row_decoder.sv
// rtl/one_hot_row_decoder.sv - one-hot row-select bus decoder with scan sequence checking
// Optional feature: ONE_HOT_ROW_DECODER_PRIORITY_EN (multi-hot decodes to lowest set bit)
module one_hot_row_decoder #(
    parameter int DWELL_W = 16,
    parameter int ERR_W   = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               sample_en,
    input  logic [7:0]         onehot_in,
    input  logic               clear,
    output logic [2:0]         row_idx,
    output logic               row_valid,
    output logic               onehot_err,
    output logic               row_change,
    output logic               frame_done,
    output logic               seq_err,
    output logic [DWELL_W-1:0] dwell_last,
    output logic [ERR_W-1:0]   illegal_cnt,
    output logic [ERR_W-1:0]   seq_err_cnt
);

    typedef enum logic [1:0] {
        HUNT = 2'd0,
        SCAN = 2'd1,
        WRAP = 2'd2
    } state_t;

    localparam logic [DWELL_W-1:0] DWELL_MAX = '1;
    localparam logic [DWELL_W-1:0] DWELL_ONE = DWELL_W'(1);
    localparam logic [ERR_W-1:0]   ERR_MAX   = '1;
    localparam logic [ERR_W-1:0]   ERR_ONE   = ERR_W'(1);

    state_t               state_q, state_d;
    logic [2:0]           expect_q, expect_d;
    logic [2:0]           row_idx_q;
    logic                 row_valid_q;
    logic                 onehot_err_q;
    logic                 row_change_q;
    logic                 frame_done_q;
    logic                 seq_err_q;
    logic                 prev_valid_q;
    logic [DWELL_W-1:0]   dwell_cnt_q;
    logic [DWELL_W-1:0]   dwell_last_q;
    logic [ERR_W-1:0]     illegal_cnt_q;
    logic [ERR_W-1:0]     seq_err_cnt_q;

    logic [2:0]           low_idx;
    logic                 low_found;
    logic                 code_zero;
    logic                 code_multi;
    logic                 code_illegal;
    logic                 code_legal;
    logic                 first_evt;
    logic                 chg_evt;
    logic                 fd_hit;
    logic                 se_hit;

    // Classify the sampled code and find its lowest set bit
    always_comb begin
        low_idx   = 3'd0;
        low_found = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (onehot_in[i] && !low_found) begin
                low_idx   = i[2:0];
                low_found = 1'b1;
            end
        end
        code_zero    = (onehot_in == 8'd0);
        code_multi   = ((onehot_in & (onehot_in - 8'd1)) != 8'd0);
        code_illegal = code_zero | code_multi;
`ifdef ONE_HOT_ROW_DECODER_PRIORITY_EN
        code_legal   = !code_zero;
`else
        code_legal   = !code_illegal;
`endif
        // row_idx_q always equals the last legal row, so it doubles as prev_row
        first_evt = code_legal && !prev_valid_q;
        chg_evt   = code_legal && prev_valid_q && (low_idx != row_idx_q);
    end

    // Scan sequence FSM: advances only on the first legal row or a legal row change
    always_comb begin
        state_d  = state_q;
        expect_d = expect_q;
        fd_hit   = 1'b0;
        se_hit   = 1'b0;
        if (first_evt || chg_evt) begin
            case (state_q)
                HUNT: begin
                    if (low_idx == 3'd0) begin
                        state_d  = SCAN;
                        expect_d = 3'd1;
                    end
                end
                SCAN: begin
                    if (low_idx == expect_q) begin
                        if (expect_q == 3'd7) state_d = WRAP;
                        else                  expect_d = expect_q + 3'd1;
                    end else begin
                        se_hit = 1'b1;
                        if (low_idx == 3'd0) expect_d = 3'd1;
                        else                 state_d  = HUNT;
                    end
                end
                WRAP: begin
                    if (low_idx == 3'd0) begin
                        fd_hit   = 1'b1;
                        state_d  = SCAN;
                        expect_d = 3'd1;
                    end else begin
                        se_hit  = 1'b1;
                        state_d = HUNT;
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    // State, counters and registered outputs; clear outranks sample_en
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= HUNT;
            expect_q      <= 3'd0;
            row_idx_q     <= 3'd0;
            row_valid_q   <= 1'b0;
            onehot_err_q  <= 1'b0;
            row_change_q  <= 1'b0;
            frame_done_q  <= 1'b0;
            seq_err_q     <= 1'b0;
            prev_valid_q  <= 1'b0;
            dwell_cnt_q   <= '0;
            dwell_last_q  <= '0;
            illegal_cnt_q <= '0;
            seq_err_cnt_q <= '0;
        end else if (clear) begin
            state_q       <= HUNT;
            expect_q      <= 3'd0;
            row_idx_q     <= 3'd0;
            row_valid_q   <= 1'b0;
            onehot_err_q  <= 1'b0;
            row_change_q  <= 1'b0;
            frame_done_q  <= 1'b0;
            seq_err_q     <= 1'b0;
            prev_valid_q  <= 1'b0;
            dwell_cnt_q   <= '0;
            dwell_last_q  <= '0;
            illegal_cnt_q <= '0;
            seq_err_cnt_q <= '0;
        end else if (sample_en) begin
            state_q      <= state_d;
            expect_q     <= expect_d;
            onehot_err_q <= code_illegal;
            row_change_q <= chg_evt;
            frame_done_q <= fd_hit;
            seq_err_q    <= se_hit;
            if (code_illegal && illegal_cnt_q != ERR_MAX)
                illegal_cnt_q <= illegal_cnt_q + ERR_ONE;
            if (se_hit && seq_err_cnt_q != ERR_MAX)
                seq_err_cnt_q <= seq_err_cnt_q + ERR_ONE;
            if (code_legal) begin
                row_valid_q  <= 1'b1;
                row_idx_q    <= low_idx;
                prev_valid_q <= 1'b1;
            end else begin
                row_valid_q  <= 1'b0;
            end
            // Dwell restarts when a new row begins; dwell_last includes the final cycle
            if (first_evt || chg_evt)
                dwell_cnt_q <= '0;
            else if (dwell_cnt_q != DWELL_MAX)
                dwell_cnt_q <= dwell_cnt_q + DWELL_ONE;
            if (chg_evt)
                dwell_last_q <= (dwell_cnt_q == DWELL_MAX) ? DWELL_MAX : dwell_cnt_q + DWELL_ONE;
        end else begin
            // Pulses last one sampled cycle; everything else holds
            onehot_err_q <= 1'b0;
            row_change_q <= 1'b0;
            frame_done_q <= 1'b0;
            seq_err_q    <= 1'b0;
        end
    end

    assign row_idx     = row_idx_q;
    assign row_valid   = row_valid_q;
    assign onehot_err  = onehot_err_q;
    assign row_change  = row_change_q;
    assign frame_done  = frame_done_q;
    assign seq_err     = seq_err_q;
    assign dwell_last  = dwell_last_q;
    assign illegal_cnt = illegal_cnt_q;
    assign seq_err_cnt = seq_err_cnt_q;

endmodule

// File: tb/tb_one_hot_row_decoder.sv
// tb/tb_one_hot_row_decoder.sv - scoreboard bench for one_hot_row_decoder
module tb_one_hot_row_decoder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sample_en = 1'b0;
    logic [7:0]  onehot_in = 8'd0;
    logic        clear = 1'b0;
    logic [2:0]  row_idx;
    logic        row_valid;
    logic        onehot_err;
    logic        row_change;
    logic        frame_done;
    logic        seq_err;
    logic [15:0] dwell_last;
    logic [7:0]  illegal_cnt;
    logic [7:0]  seq_err_cnt;

    int checks = 0;
    int failures = 0;
    int fd_seen = 0;
    int se_seen = 0;

    logic [39:0] exp_q[$];

    // reference model state
    logic [2:0] m_row;
    logic       m_valid, m_err, m_chg, m_fd, m_se, m_pv;
    int         m_dl, m_ic, m_sc, m_cnt, m_st, m_exp;

    one_hot_row_decoder #(.DWELL_W(16), .ERR_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .sample_en(sample_en), .onehot_in(onehot_in),
        .clear(clear), .row_idx(row_idx), .row_valid(row_valid), .onehot_err(onehot_err),
        .row_change(row_change), .frame_done(frame_done), .seq_err(seq_err),
        .dwell_last(dwell_last), .illegal_cnt(illegal_cnt), .seq_err_cnt(seq_err_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [39:0] dut_pack();
        return {row_idx, row_valid, onehot_err, row_change, frame_done, seq_err,
                dwell_last, illegal_cnt, seq_err_cnt};
    endfunction

    function automatic logic [39:0] model_pack();
        return {m_row, m_valid, m_err, m_chg, m_fd, m_se, 16'(m_dl), 8'(m_ic), 8'(m_sc)};
    endfunction

    task automatic model_reset();
        m_row = 3'd0; m_valid = 0; m_err = 0; m_chg = 0; m_fd = 0; m_se = 0; m_pv = 0;
        m_dl = 0; m_ic = 0; m_sc = 0; m_cnt = 0; m_st = 0; m_exp = 0;
    endtask

    task automatic model_seq_error();
        m_se = 1;
        if (m_sc < 255) m_sc++;
    endtask

    // 0 = waiting for row 0, 1 = scanning, 2 = row 7 seen, waiting for 0
    task automatic model_fsm(input int r);
        case (m_st)
            0: if (r == 0) begin m_st = 1; m_exp = 1; end
            1: begin
                if (r == m_exp) begin
                    if (m_exp == 7) m_st = 2;
                    else m_exp++;
                end else begin
                    model_seq_error();
                    if (r == 0) m_exp = 1;
                    else m_st = 0;
                end
            end
            default: begin
                if (r == 0) begin m_fd = 1; m_st = 1; m_exp = 1; end
                else begin model_seq_error(); m_st = 0; end
            end
        endcase
    endtask

    task automatic model_step(input logic clr, input logic en, input logic [7:0] code);
        int  n;
        int  lo;
        bit  legal;
        m_err = 0; m_chg = 0; m_fd = 0; m_se = 0;
        if (clr) begin
            model_reset();
        end else if (en) begin
            n  = $countones(code);
            lo = 0;
            for (int b = 7; b >= 0; b--) if (code[b]) lo = b;
`ifdef ONE_HOT_ROW_DECODER_PRIORITY_EN
            legal = (n > 0);
`else
            legal = (n == 1);
`endif
            if (n != 1) begin
                m_err = 1;
                if (m_ic < 255) m_ic++;
            end
            if (legal) begin
                m_valid = 1;
                if (!m_pv || lo != int'(m_row)) begin
                    if (m_pv) begin
                        m_chg = 1;
                        m_dl  = (m_cnt >= 65535) ? 65535 : m_cnt + 1;
                    end
                    m_cnt = 0;
                    m_pv  = 1;
                    m_row = 3'(lo);
                    model_fsm(lo);
                end else if (m_cnt < 65535) m_cnt++;
            end else begin
                m_valid = 0;
                if (m_cnt < 65535) m_cnt++;
            end
        end else begin
            // sample_en low: state holds, pulses already cleared above
        end
    endtask

    task automatic step(input logic clr, input logic en, input logic [7:0] code);
        @(negedge clk);
        clear = clr; sample_en = en; onehot_in = code;
        model_step(clr, en, code);
        exp_q.push_back(model_pack());
        @(posedge clk);
        #1;
        check_eq("cycle", {24'd0, dut_pack()}, {24'd0, exp_q.pop_front()});
        fd_seen += int'(frame_done);
        se_seen += int'(seq_err);
    endtask

    task automatic row(input logic [7:0] code);
        step(1'b0, 1'b1, code);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; sample_en = 1'b0; clear = 1'b0;
        model_reset();
        exp_q.delete();
        #1;
        check_eq("reset_outs", {24'd0, dut_pack()}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int fd0, se0;
        model_reset();
        do_reset();

        // first legal row: valid, no change pulse
        row(8'h01);
        check_eq("first_valid", 64'(row_valid), 64'd1);
        check_eq("first_no_chg", 64'(row_change), 64'd0);

        // full frame, 5 cycles per row
        fd0 = fd_seen;
        repeat (4) row(8'h01);
        for (int r = 1; r <= 8; r++) begin
            logic [7:0] code;
            code = 8'h01 << (r % 8);
            row(code);
            check_eq("dwell5", 64'(dwell_last), 64'd5);
            if (r < 8) repeat (4) row(code);
        end
        check_eq("frame_once", 64'(fd_seen - fd0), 64'd1);
        check_eq("seq_cnt0", 64'(seq_err_cnt), 64'd0);

        // out-of-order with expect=3
        row(8'h02);
        row(8'h04);
        row(8'h20);
        check_eq("seq_pulse", 64'(seq_err), 64'd1);
        check_eq("seq_cnt1", 64'(seq_err_cnt), 64'd1);
        row(8'h01);
        check_eq("hunt_no_fd", 64'(frame_done), 64'd0);

        // blanking and multi-hot between rows 2 and 3
        row(8'h02);
        row(8'h04);
        row(8'h00);
        check_eq("blank_err", 64'(onehot_err), 64'd1);
        check_eq("blank_invalid", 64'(row_valid), 64'd0);
        check_eq("blank_hold", 64'(row_idx), 64'd2);
        row(8'h06);
        check_eq("multi_err", 64'(onehot_err), 64'd1);
        check_eq("ill_cnt2", 64'(illegal_cnt), 64'd2);
`ifdef ONE_HOT_ROW_DECODER_PRIORITY_EN
        check_eq("multi_idx", 64'(row_idx), 64'd1);
        check_eq("multi_valid", 64'(row_valid), 64'd1);
        check_eq("multi_seq", 64'(seq_err), 64'd1);
`else
        check_eq("multi_idx", 64'(row_idx), 64'd2);
        check_eq("multi_invalid", 64'(row_valid), 64'd0);
`endif
        row(8'h08);

        // dwell saturation
        repeat (70000) row(8'h04);
        row(8'h08);
        check_eq("dwell_sat", 64'(dwell_last), 64'd65535);

        // sample_en low holds everything
        step(1'b0, 1'b0, 8'h80);
        check_eq("hold_idx", 64'(row_idx), 64'd3);

        // reset mid-frame at row 5
        for (int r = 0; r <= 5; r++) begin
            logic [7:0] code;
            code = 8'h01 << r;
            row(code);
        end
        do_reset();
        fd0 = fd_seen;
        se0 = se_seen;
        row(8'h40);
        for (int r = 0; r < 8; r++) begin
            logic [7:0] code;
            code = 8'h01 << r;
            row(code);
        end
        check_eq("post_rst_no_fd", 64'(fd_seen - fd0), 64'd0);
        row(8'h01);
        check_eq("post_rst_fd", 64'(fd_seen - fd0), 64'd1);
        check_eq("post_rst_no_se", 64'(se_seen - se0), 64'd0);

        // build up counters, then clear
        row(8'h00);
        row(8'h20);
        row(8'hC0);
        step(1'b1, 1'b1, 8'h00);
        check_eq("clr_ill", 64'(illegal_cnt), 64'd0);
        check_eq("clr_seq", 64'(seq_err_cnt), 64'd0);
        row(8'h10);
        row(8'h01);
        row(8'h02);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
